div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Iterative RV32M divide/remainder unit in the EX stage. It computes DIV, DIVU, REM and REMU.
//  It is the stall-request source that feeds the hazard unit: BusyE holds F/D/E and bubbles M
//  until the result is ready. One quotient bit per cycle (restoring); fast path for special cases.
// PARAMETERS
//  XLEN    32   operand/result width
// PORTS
//  clk      in   1     clock, rising edge
//  reset    in   1     synchronous, active-high reset
//  StartE   in   1     EX holds a valid divide op (from decode, gated by ID/EX valid)
//  FunctE   in   2     00=DIV 01=DIVU 10=REM 11=REMU
//  SrcAE    in   XLEN  dividend (post-forwarding)
//  SrcBE    in   XLEN  divisor (post-forwarding)
//  KillE    in   1     abandon op in flight (trap/flush of EX)
//  BusyE    out  1     stall request to hazard unit (StallF/StallD/StallE, FlushM)
//  DoneE    out  1     ResultE valid this cycle; pipeline advances at this edge
//  ResultE  out  XLEN  quotient or remainder
// BEHAVIOUR
//  Reset: state=IDLE; DoneE=0; ResultE=0; internal regs cleared; BusyE=0 unless StartE.
//  FSM IDLE -> CALC -> DONE -> IDLE; fast path IDLE -> DONE.
//  IDLE, StartE=1, KillE=0:
//   - latch |A|, |B| (signed ops) or raw A, B; latch FunctE and the sign flags.
//   - B==0, or DIV/REM with A==-2^(XLEN-1) and B==-1 -> DONE next cycle.
//   - otherwise -> CALC with cnt=XLEN-1.
//  CALC: one restoring step per cycle.
//   - shift {rem,quo} left; trial subtract; set quo bit.
//   - cnt decrements each step; when cnt==0 -> DONE.
//  DONE: DoneE=1; ResultE driven; -> IDLE unconditionally.
//  BusyE = ~KillE & ((state==IDLE & StartE) | state==CALC); it is 0 in DONE.
//  Latency, normal op: XLEN+2 cycles in EX, i.e. XLEN+1 stall cycles.
//  Latency, fast path: 2 cycles in EX, i.e. 1 stall cycle.
//  Result rules, sign fix-up, applied in DONE:
//   - quotient negated iff signed op and sign(A)!=sign(B).
//   - remainder negated iff signed op and A negative.
//   - divide by zero: Q=all ones (-1); R=A (unmodified dividend); applies to signed and unsigned.
//   - overflow (DIV/REM, -2^(XLEN-1)/-1): Q=A; R=0.
//  ResultE is registered and held from DONE until the next DONE. It is valid only when DoneE=1.
//  Operands sample only in IDLE. SrcAE/SrcBE changes during CALC are ignored.
//  The unit never restarts the same instruction. It re-arms in IDLE the cycle after DONE, so a
//  back-to-back divide in the next EX slot starts cleanly.
//  KillE: in any state, next state=IDLE, DoneE=0 next cycle, BusyE=0 the same cycle.
//  KillE with StartE in IDLE does not start an op.
//  reset mid-op: same effect as KillE plus output clear. Next StartE begins a fresh op.
//  StartE=0 in CALC (must not happen with a correct stall) is ignored; op completes.
// TESTING
//  DIVU 100/7: BusyE high 33 cycles; DoneE 1 cycle; ResultE=14. REMU same operands -> 2.
//  DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); REM 7/-2 -> 1.
//  DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each with exactly 1 stall cycle.
//  DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; 1 stall cycle.
//  Kill/reset mid-op: KillE at CALC cycle 10 -> BusyE=0 same cycle, no DoneE.
//   Next DIVU 9/3 -> 3 after 33 cycles. Same check with reset at CALC cycle 5.
//  Back-to-back: DIVU 50/5 then REMU 50/7 in consecutive EX slots -> 10 then 1.
//   No lost or duplicated DoneE.

Source files
------------

// File: rtl/div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU in EX.
// Retires one quotient bit per cycle. Divide-by-zero and signed overflow take a two-cycle fast path.
module div_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            StartE,
   input  logic [1:0]      FunctE,
   input  logic [XLEN-1:0] SrcAE,
   input  logic [XLEN-1:0] SrcBE,
   input  logic            KillE,
   output logic            BusyE,
   output logic            DoneE,
   output logic [XLEN-1:0] ResultE
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state_reg, state_next;
   logic [CW-1:0]     cnt_reg;
   logic [XLEN-1:0]   rem_reg, quo_reg, div_reg, result_reg;
   logic              neg_q_reg, neg_r_reg, is_rem_reg;

   logic              start_ok, signed_op, div_zero, overflow, fast;
   logic [XLEN-1:0]   a_abs, b_abs, fast_result;
   logic [XLEN:0]     trial;
   logic              take;
   logic [XLEN-1:0]   rem_step, quo_step, q_fix, r_fix, calc_result;

   // Operand decode, only meaningful while IDLE
   always_comb begin
      start_ok    = StartE & ~KillE;
      signed_op   = ~FunctE[0];
      a_abs       = (signed_op & SrcAE[XLEN-1]) ? -SrcAE : SrcAE;
      b_abs       = (signed_op & SrcBE[XLEN-1]) ? -SrcBE : SrcBE;
      div_zero    = (SrcBE == '0);
      overflow    = signed_op & (SrcAE == MIN_NEG) & (SrcBE == '1);
      fast        = div_zero | overflow;
      if (div_zero)
         fast_result = FunctE[1] ? SrcAE : '1;
      else
         fast_result = FunctE[1] ? '0 : SrcAE;
   end

   // One restoring step: bit XLEN of the trial difference is the borrow
   always_comb begin
      trial       = {rem_reg, quo_reg[XLEN-1]} - {1'b0, div_reg};
      take        = ~trial[XLEN];
      rem_step    = take ? trial[XLEN-1:0] : {rem_reg[XLEN-2:0], quo_reg[XLEN-1]};
      quo_step    = {quo_reg[XLEN-2:0], take};
      q_fix       = neg_q_reg ? -quo_step : quo_step;
      r_fix       = neg_r_reg ? -rem_step : rem_step;
      calc_result = is_rem_reg ? r_fix : q_fix;
   end

   always_ff @(posedge clk) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      BusyE      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start_ok) begin
               BusyE      = 1'b1;
               state_next = fast ? DONE : CALC;
            end
         end
         CALC: begin
            BusyE = 1'b1;
            if (cnt_reg == '0) state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (KillE) begin
         state_next = IDLE;
         BusyE      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_reg    <= '0;
         rem_reg    <= '0;
         quo_reg    <= '0;
         div_reg    <= '0;
         result_reg <= '0;
         neg_q_reg  <= 1'b0;
         neg_r_reg  <= 1'b0;
         is_rem_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start_ok) begin
                  cnt_reg    <= CW'(XLEN-1);
                  rem_reg    <= '0;
                  quo_reg    <= a_abs;
                  div_reg    <= b_abs;
                  is_rem_reg <= FunctE[1];
                  neg_q_reg  <= signed_op & (SrcAE[XLEN-1] ^ SrcBE[XLEN-1]);
                  neg_r_reg  <= signed_op & SrcAE[XLEN-1];
                  if (fast) result_reg <= fast_result;
               end
            end
            CALC: begin
               rem_reg <= rem_step;
               quo_reg <= quo_step;
               cnt_reg <= cnt_reg - 1'b1;
               if ((cnt_reg == '0) && !KillE) result_reg <= calc_result;
            end
            default: ;
         endcase
      end
   end

   assign DoneE   = (state_reg == DONE);
   assign ResultE = result_reg;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: results, stall length, fast paths, kill/reset abort, back-to-back ops.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        StartE;
   logic [1:0]  FunctE;
   logic [31:0] SrcAE, SrcBE;
   logic        KillE;
   logic        BusyE, DoneE;
   logic [31:0] ResultE;

   int total = 0;
   int bad   = 0;

   localparam logic [1:0] F_DIV = 2'b00, F_DIVU = 2'b01, F_REM = 2'b10, F_REMU = 2'b11;

   always #5 clk = ~clk;

   div_unit #(.XLEN(32)) dut (
      .clk(clk), .reset(reset), .StartE(StartE), .FunctE(FunctE),
      .SrcAE(SrcAE), .SrcBE(SrcBE), .KillE(KillE),
      .BusyE(BusyE), .DoneE(DoneE), .ResultE(ResultE)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s: got=%h want=%h", tag, got, want);
      end
   endtask

   // Issue one op in the next EX slot and follow it to DoneE; operands are scrambled after cycle 0
   task automatic do_op(input string tag, input logic [1:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] want, input int want_busy);
      int busy_n;
      bit seen;
      @(negedge clk);
      StartE = 1'b1; FunctE = f; SrcAE = a; SrcBE = b;
      busy_n = 0; seen = 1'b0;
      #1 check({tag, "_done_at_start"}, 32'(DoneE), 32'd0);
      for (int c = 0; c < 60 && !seen; c++) begin
         if (c > 0) begin
            @(negedge clk);
            SrcAE = $urandom; SrcBE = $urandom;
            #1;
         end
         if (DoneE) begin
            seen = 1'b1;
            check({tag, "_result"}, ResultE, want);
            check({tag, "_busy_in_done"}, 32'(BusyE), 32'd0);
         end else if (BusyE) begin
            busy_n++;
         end
      end
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
      check({tag, "_busy_cycles"}, 32'(busy_n), 32'(want_busy));
      $display("op %s f=%0d a=%h b=%h result=%h busy=%0d", tag, f, a, b, ResultE, busy_n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; StartE = 1'b0; FunctE = 2'b00; SrcAE = '0; SrcBE = '0; KillE = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("reset_busy", 32'(BusyE), 32'd0);
      check("reset_done", 32'(DoneE), 32'd0);
      check("reset_result", ResultE, 32'd0);
      reset = 1'b0;
      $display("step reset released");

      do_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 32'd14, 33);
      do_op("remu_100_7", F_REMU, 32'd100, 32'd7, 32'd2, 33);
      do_op("div_m7_2",   F_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
      do_op("rem_m7_2",   F_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
      do_op("rem_7_m2",   F_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 33);
      do_op("div_m100_m7", F_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 33);
      do_op("rem_m100_m7", F_REM, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 33);
      do_op("divu_max_1", F_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
      do_op("remu_max_16", F_REMU, 32'hFFFF_FFFF, 32'd16, 32'd15, 33);
      do_op("divu_min_m1", F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
      do_op("div_5_0",    F_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1);
      do_op("remu_5_0",   F_REMU, 32'd5, 32'd0, 32'd5, 1);
      do_op("divu_5_0",   F_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
      do_op("rem_m7_0",   F_REM,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1);
      do_op("div_ovf",    F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      do_op("rem_ovf",    F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
      @(negedge clk); StartE = 1'b0;

      // Kill at CALC cycle 10
      @(negedge clk);
      StartE = 1'b1; FunctE = F_DIVU; SrcAE = 32'd1000; SrcBE = 32'd3;
      repeat (10) @(negedge clk);
      KillE = 1'b1;
      #1 check("kill_busy_same_cycle", 32'(BusyE), 32'd0);
      @(negedge clk);
      KillE = 1'b0; StartE = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("kill_no_done", 32'(DoneE), 32'd0);
         check("kill_idle_busy", 32'(BusyE), 32'd0);
         @(negedge clk);
      end
      $display("step kill at calc cycle 10");
      do_op("divu_9_3_after_kill", F_DIVU, 32'd9, 32'd3, 32'd3, 33);
      @(negedge clk); StartE = 1'b0;

      // Reset at CALC cycle 5 clears outputs
      @(negedge clk);
      StartE = 1'b1; FunctE = F_DIVU; SrcAE = 32'd1000; SrcBE = 32'd7;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; StartE = 1'b0;
      #1;
      check("rst_mid_done", 32'(DoneE), 32'd0);
      check("rst_mid_result", ResultE, 32'd0);
      check("rst_mid_busy", 32'(BusyE), 32'd0);
      $display("step reset at calc cycle 5");
      do_op("divu_9_3_after_reset", F_DIVU, 32'd9, 32'd3, 32'd3, 33);
      @(negedge clk); StartE = 1'b0;

      // Kill together with Start in IDLE must not launch an op
      @(negedge clk);
      StartE = 1'b1; KillE = 1'b1; FunctE = F_DIVU; SrcAE = 32'd77; SrcBE = 32'd5;
      #1 check("kill_start_busy", 32'(BusyE), 32'd0);
      @(negedge clk);
      StartE = 1'b0; KillE = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("kill_start_no_busy", 32'(BusyE), 32'd0);
         check("kill_start_no_done", 32'(DoneE), 32'd0);
         @(negedge clk);
      end
      $display("step kill with start in idle");

      // Back-to-back in consecutive EX slots
      do_op("b2b_divu_50_5", F_DIVU, 32'd50, 32'd5, 32'd10, 33);
      do_op("b2b_remu_50_7", F_REMU, 32'd50, 32'd7, 32'd1, 33);
      @(negedge clk); StartE = 1'b0;
      #1 check("b2b_no_dup_done", 32'(DoneE), 32'd0);
      @(negedge clk);
      #1 check("b2b_no_dup_done2", 32'(DoneE), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
